// File: rtl/core_pkg.sv
// Shared types and defaults for the multi-cycle core sequencer: state
// encoding, write-back source select and parameter defaults.
package core_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int RESET_PC_DEF = 0;
    localparam int TIMEOUT_DEF  = 16;
    localparam int CNT_W_DEF    = 32;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        WB_PC4     = 2'd0,
        WB_ALU     = 2'd1,
        WB_LOAD    = 2'd2,
        WB_ALU_ALT = 2'd3
    } wb_sel_t;

    // Instruction addresses must be word aligned.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-cycle counter shared by the instruction and data memory waits.
// expired is high in the waiting cycle that reaches LIMIT without an ack.
module mc_wait_timer
    import core_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    assign expired = count && (cnt_q == W'(LIMIT - 1));

    // Saturates at LIMIT-1; the sequencer leaves the waiting state on expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count && !expired) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/mc_core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// with a sticky FAULT state for memory timeouts and misaligned next-pc.
module mc_core_sequencer
    import core_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int               TIMEOUT  = TIMEOUT_DEF,
    parameter int               CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    // Instruction fetch port
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    // Data memory port
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    // Decoder controls, sampled in DECODE
    input  logic              ctrl_rd_en,
    input  logic              ctrl_wr_en,
    input  logic              ctrl_reg_wr,
    input  logic [1:0]        ctrl_wb_sel,
    input  logic              br_taken,
    // Datapath results, sampled in EXEC
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   store_data,
    // Status
    output logic [XLEN-1:0]   pc,
    output logic [31:0]       instr,
    output logic              reg_wr_en,
    output logic [XLEN-1:0]   wb_data,
    output logic              retire,
    output logic [CNT_W-1:0]  instret,
    output logic              fault,
    output logic [2:0]        state
);

    // Memory handshake (both ports): req and its address/data are held
    // stable from the first request cycle through the cycle in which ack is
    // sampled high; ack in the same cycle as req completes the transfer, and
    // ack seen while the port is not requesting is ignored.

    state_t           state_q;
    logic [XLEN-1:0]  pc_q;
    logic [31:0]      instr_q;
    logic [CNT_W-1:0] instret_q;
    logic             fault_q;

    logic             ctrl_rd_q;
    logic             ctrl_wr_q;
    logic             ctrl_reg_wr_q;
    wb_sel_t          wb_sel_q;
    logic             br_taken_q;

    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  sdata_q;
    logic [XLEN-1:0]  ld_q;

    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  next_pc;
    logic             pc_bad;
    logic             in_fetch;
    logic             in_mem;
    logic             in_wb;
    logic             tmr_clear;
    logic             tmr_count;
    logic             tmr_expired;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign next_pc  = br_taken_q ? alu_q : pc_plus4;
    assign pc_bad   = misaligned(next_pc[1:0]);

    assign in_fetch = (state_q == ST_FETCH);
    assign in_mem   = (state_q == ST_MEM);
    assign in_wb    = (state_q == ST_WB);

    // The timer only runs while waiting on a memory port; every other state
    // holds it at zero, so each FETCH or MEM visit starts from a clean count.
    assign tmr_clear = !(in_fetch || in_mem);
    assign tmr_count = (in_fetch && !imem_ack) || (in_mem && !dmem_ack);

    mc_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    // Port strobes are decoded from the registered state; rst gates them so
    // nothing is requested while reset is held even though state reads FETCH.
    assign imem_req   = in_fetch && !rst;
    assign imem_addr  = pc_q;
    assign dmem_req   = in_mem && !rst;
    assign dmem_we    = in_mem && ctrl_wr_q && !rst;
    assign dmem_addr  = alu_q;
    assign dmem_wdata = sdata_q;

    assign reg_wr_en  = in_wb && ctrl_reg_wr_q;
    assign retire     = in_wb && !pc_bad;

    assign pc         = pc_q;
    assign instr      = instr_q;
    assign instret    = instret_q;
    assign fault      = fault_q;
    assign state      = state_q;

    always_comb begin
        wb_data = alu_q;
        case (wb_sel_q)
            WB_PC4:  wb_data = pc_plus4;
            WB_LOAD: wb_data = ld_q;
            default: wb_data = alu_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instret_q     <= '0;
            fault_q       <= 1'b0;
            ctrl_rd_q     <= 1'b0;
            ctrl_wr_q     <= 1'b0;
            ctrl_reg_wr_q <= 1'b0;
            wb_sel_q      <= WB_PC4;
            br_taken_q    <= 1'b0;
            alu_q         <= '0;
            sdata_q       <= '0;
            ld_q          <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= ST_DECODE;
                    end else if (tmr_expired) begin
                        fault_q <= 1'b1;
                        state_q <= ST_FAULT;
                    end
                end
                ST_DECODE: begin
                    ctrl_rd_q     <= ctrl_rd_en;
                    ctrl_wr_q     <= ctrl_wr_en;
                    ctrl_reg_wr_q <= ctrl_reg_wr;
                    wb_sel_q      <= wb_sel_t'(ctrl_wb_sel);
                    br_taken_q    <= br_taken;
                    state_q       <= ST_EXEC;
                end
                ST_EXEC: begin
                    alu_q   <= alu_out;
                    sdata_q <= store_data;
                    state_q <= (ctrl_rd_q || ctrl_wr_q) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        ld_q    <= dmem_rdata;
                        state_q <= ST_WB;
                    end else if (tmr_expired) begin
                        fault_q <= 1'b1;
                        state_q <= ST_FAULT;
                    end
                end
                ST_WB: begin
                    // A misaligned target faults without committing pc or count.
                    if (pc_bad) begin
                        fault_q <= 1'b1;
                        state_q <= ST_FAULT;
                    end else begin
                        pc_q      <= next_pc;
                        instret_q <= instret_q + CNT_W'(1);
                        state_q   <= ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end
                default: begin
                    fault_q <= 1'b1;
                    state_q <= ST_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_core_sequencer.sv
// Directed bench for mc_core_sequencer: behaves as memories and decoder,
// predicts write-back data / pc / instret and compares at retire.
module tb_mc_core_sequencer;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_ack = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic              dmem_req;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_ack = 1'b0;
    logic [XLEN-1:0]   dmem_rdata = '0;
    logic              ctrl_rd_en = 1'b0;
    logic              ctrl_wr_en = 1'b0;
    logic              ctrl_reg_wr = 1'b0;
    logic [1:0]        ctrl_wb_sel = 2'd0;
    logic              br_taken = 1'b0;
    logic [XLEN-1:0]   alu_out = '0;
    logic [XLEN-1:0]   store_data = '0;
    logic [XLEN-1:0]   pc;
    logic [31:0]       instr;
    logic              reg_wr_en;
    logic [XLEN-1:0]   wb_data;
    logic              retire;
    logic [CNT_W-1:0]  instret;
    logic              fault;
    logic [2:0]        state;

    mc_core_sequencer #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .ctrl_rd_en  (ctrl_rd_en),
        .ctrl_wr_en  (ctrl_wr_en),
        .ctrl_reg_wr (ctrl_reg_wr),
        .ctrl_wb_sel (ctrl_wb_sel),
        .br_taken    (br_taken),
        .alu_out     (alu_out),
        .store_data  (store_data),
        .pc          (pc),
        .instr       (instr),
        .reg_wr_en   (reg_wr_en),
        .wb_data     (wb_data),
        .retire      (retire),
        .instret     (instret),
        .fault       (fault),
        .state       (state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0]  exp_q[$];
    logic [XLEN-1:0]  pc_model;
    logic [CNT_W-1:0] icnt_model;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst      = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        step();
        step();
        check("rst_state", state, 0);
        check("rst_pc", pc, 0);
        check("rst_instr", instr, 0);
        check("rst_instret", instret, 0);
        check("rst_fault", fault, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_retire", retire, 0);
        check("rst_reg_wr_en", reg_wr_en, 0);
        rst = 1'b0;
        #1;
        check("release_imem_req", imem_req, 1);
        check("release_state", state, 0);
        pc_model   = '0;
        icnt_model = '0;
        exp_q.delete();
    endtask

    // Runs one instruction from FETCH through WB, acting as both memories.
    task automatic run_instr(input string tag, input logic rd, input logic wr, input logic rw,
                             input logic [1:0] sel, input logic br, input logic [31:0] alu,
                             input logic [31:0] sd, input int iwait, input int dwait,
                             input logic [31:0] rdata, input int exp_cycles);
        int cyc = 0;
        int iw = 0;
        int dw = 0;
        int pulses = 0;
        int hold = 0;
        bit done = 0;
        bit retired = 0;
        bit faulted;
        logic [31:0] npc;
        logic [31:0] exp_wb;
        logic [31:0] got;
        logic [31:0] iword;

        npc     = br ? alu : pc_model + 32'd4;
        faulted = (npc[1:0] != 2'b00);
        case (sel)
            2'd0:    exp_wb = pc_model + 32'd4;
            2'd2:    exp_wb = rdata;
            default: exp_wb = alu;
        endcase
        if (!faulted) exp_q.push_back(exp_wb);

        iword       = $urandom;
        imem_rdata  = iword;
        ctrl_rd_en  = rd;
        ctrl_wr_en  = wr;
        ctrl_reg_wr = rw;
        ctrl_wb_sel = sel;
        br_taken    = br;
        alu_out     = alu;
        store_data  = sd;
        dmem_rdata  = rdata;

        while (!done && cyc < 64) begin
            cyc++;
            imem_ack = (state == 3'd0) && (iw == iwait);
            dmem_ack = (state == 3'd3) && (dw == dwait);
            if (state == 3'd0) begin
                if (iw == 0) check({tag, "_imem_addr"}, imem_addr, pc_model);
                iw++;
            end
            if (state == 3'd3) begin
                if (dmem_req && dmem_addr === alu && dmem_we === wr && dmem_wdata === sd) hold++;
                dw++;
            end
            if (state == 3'd1) check({tag, "_instr"}, instr, iword);
            if (reg_wr_en) pulses++;
            if (state == 3'd4) begin
                done = 1;
                if (retire) begin
                    retired = 1;
                    got = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    check({tag, "_wb_data"}, wb_data, got);
                end
            end
            if (state == 3'd5) done = 1;
            step();
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
        end

        check({tag, "_cycles"}, cyc, exp_cycles);
        check({tag, "_reg_wr_pulses"}, pulses, rw);
        check({tag, "_retire"}, retired, !faulted);
        if (rd || wr) check({tag, "_dmem_hold"}, hold, dwait + 1);
        if (faulted) begin
            check({tag, "_fault"}, fault, 1);
            check({tag, "_fault_state"}, state, 5);
            check({tag, "_fault_pc"}, pc, pc_model);
            check({tag, "_fault_instret"}, instret, icnt_model);
        end else begin
            pc_model   = npc;
            icnt_model = icnt_model + 1'b1;
            check({tag, "_pc"}, pc, pc_model);
            check({tag, "_instret"}, instret, icnt_model);
            check({tag, "_state"}, state, 0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int iw;

        apply_reset();

        // ALU op, zero-wait fetch, write-back of alu result
        run_instr("alu", 0, 0, 1, 2'd1, 0, 32'h5, 32'h0, 0, 0, 32'h0, 4);
        // Load with three wait cycles on the data port
        run_instr("load", 1, 0, 1, 2'd2, 0, 32'h100, 32'h0, 0, 3, 32'hDEADBEEF, 8);
        // Store, zero wait, no register write, wb_data = pc+4
        run_instr("store", 0, 1, 0, 2'd0, 0, 32'h200, 32'h1234_5678, 0, 0, 32'h0, 5);
        // wb_sel 3 with a slow fetch
        run_instr("sel3", 0, 0, 1, 2'd3, 0, 32'hA5A5_0000, 32'h0, 2, 0, 32'h0, 6);
        // Taken branch to an aligned target
        run_instr("br_ok", 0, 0, 1, 2'd0, 1, 32'h40, 32'h0, 0, 0, 32'h0, 4);
        // Taken branch to a misaligned target faults
        run_instr("br_bad", 0, 0, 0, 2'd1, 1, 32'h42, 32'h0, 0, 0, 32'h0, 4);

        for (int i = 0; i < 4; i++) begin
            imem_ack = $urandom_range(0, 1);
            dmem_ack = $urandom_range(0, 1);
            step();
            check("fault_sticky_imem_req", imem_req, 0);
            check("fault_sticky_dmem_req", dmem_req, 0);
            check("fault_sticky_state", state, 5);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        // Retired-instruction counter wraps at 2^CNT_W
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            iw = $urandom_range(0, 2);
            run_instr("wrap", 0, 0, 1, 2'd1, 0, $urandom, 32'h0, iw, 0, 32'h0, 4 + iw);
        end
        check("instret_wrap", instret, 0);

        // Reset asserted while a load is waiting in MEM
        ctrl_rd_en  = 1'b1;
        ctrl_wr_en  = 1'b0;
        ctrl_reg_wr = 1'b1;
        ctrl_wb_sel = 2'd2;
        br_taken    = 1'b0;
        alu_out     = 32'h300;
        imem_ack    = 1'b1;
        n = 0;
        while (state !== 3'd3 && n < 10) begin
            step();
            n++;
        end
        imem_ack = 1'b0;
        check("mid_mem_dmem_req", dmem_req, 1);
        check("mid_mem_dmem_addr", dmem_addr, 32'h300);
        rst = 1'b1;
        #1;
        check("mid_mem_rst_dmem_req", dmem_req, 0);
        check("mid_mem_rst_pc", pc, 0);
        check("mid_mem_rst_state", state, 0);
        check("mid_mem_rst_imem_req", imem_req, 0);
        step();
        rst = 1'b0;
        #1;
        check("mid_mem_release_imem_req", imem_req, 1);
        dmem_ack = 1'b1;
        step();
        step();
        check("late_dmem_ack_state", state, 0);
        check("late_dmem_ack_dmem_req", dmem_req, 0);
        dmem_ack = 1'b0;

        // Fetch timeout: imem_ack never arrives
        apply_reset();
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("timeout_fetch_cycles", n, TIMEOUT);
        check("timeout_fault", fault, 1);
        check("timeout_state", state, 5);
        for (int i = 0; i < 3; i++) begin
            step();
            check("timeout_imem_req", imem_req, 0);
            check("timeout_dmem_req", dmem_req, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mc_core_sequencer.md
MC_CORE_SEQUENCER -- requirements
Module: mc_core_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/address width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning PC value on reset.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning maximum memory wait cycles before fault.
REQ-004 SHALL have parameter CNT_W, default 32, meaning retired-instruction counter width.
REQ-005 SHALL have one clock and asynchronous active-high reset: clk in 1 system clock; rst in 1 async reset, active-high.
REQ-006 SHALL provide the instruction-fetch ports: imem_req out 1 fetch request; imem_addr out XLEN fetch address; imem_ack in 1 fetch done; imem_rdata in 32 instruction word.
REQ-007 SHALL provide the data-memory ports: dmem_req out 1 access request; dmem_we out 1 write; dmem_addr out XLEN; dmem_wdata out XLEN; dmem_ack in 1; dmem_rdata in XLEN.
REQ-008 SHALL take these decoder inputs, each sampled in DECODE: ctrl_rd_en in 1 (load); ctrl_wr_en in 1 (store); ctrl_reg_wr in 1; ctrl_wb_sel in 2; br_taken in 1.
REQ-009 SHALL take these datapath inputs: alu_out in XLEN; store_data in XLEN.
REQ-010 SHALL provide these outputs: pc out XLEN; instr out 32; reg_wr_en out 1; wb_data out XLEN; retire out 1; instret out CNT_W; fault out 1; state out 3.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5, with state reflecting the current state.
REQ-012 FETCH: imem_req=1 and imem_addr=pc; on imem_ack=1, instr<=imem_rdata and next state is DECODE; acknowledgement in the same cycle as the request is legal.
REQ-013 DECODE: lasts exactly one cycle; control inputs are registered; next state is EXEC.
REQ-014 EXEC: lasts one cycle; alu_q<=alu_out and sdata_q<=store_data; next state is MEM if ctrl_rd_en or ctrl_wr_en, else WB.
REQ-015 MEM: dmem_req=1, dmem_we=ctrl_wr_en, dmem_addr=alu_q, dmem_wdata=sdata_q, all held stable until dmem_ack; on ack, ld_q<=dmem_rdata and next state is WB.
REQ-016 WB: lasts one cycle; reg_wr_en=ctrl_reg_wr; wb_data is pc+4 for wb_sel 0, alu_q for 1, ld_q for 2, alu_q for 3.
REQ-017 WB: next pc is alu_q if br_taken, else pc+4 (modulo 2^XLEN); retire=1 for one cycle; instret increments, wrapping at 2^CNT_W; next state is FETCH.
REQ-018 WB: if the next pc has [1:0]!=0, pc SHALL NOT update, retire=0, and next state is FAULT.
REQ-019 A wait counter clears on entry to FETCH or MEM and increments each cycle without ack; reaching TIMEOUT without ack moves the block to FAULT.
REQ-020 FAULT: sticky until rst; fault=1; all requests 0; reg_wr_en=0.
REQ-021 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-022 Outside WB: reg_wr_en=0 and retire=0. Outside MEM: dmem_req=0 and dmem_we=0.
REQ-023 Minimum latency: 4 cycles per non-memory instruction and 5 cycles per load/store, with zero-wait acks.

Reset
REQ-024 rst=1 SHALL force immediately, independent of clk: state=FETCH, pc=RESET_PC, instr=0, instret=0, fault=0, wait counter=0, all internal latches 0.
REQ-025 During rst, SHALL drive imem_req=0, dmem_req=0, reg_wr_en=0, retire=0; imem_req rises in the first cycle after release.
REQ-026 Reset mid-MEM or mid-FETCH SHALL abandon the access; a late ack after release is ignored unless the block is in FETCH.

Structure
REQ-027 A shared package core_pkg SHALL hold the state enum, wb_sel encodings, and parameter defaults.
REQ-028 The wait/timeout counter SHALL be one sub-module, mc_wait_timer (clear, count, expired), shared by FETCH and MEM.

Verification
REQ-029 Reset: rst asserted in MEM with dmem_req=1 -> dmem_req=0 the same cycle, pc=0; after release, imem_req=1, state=0.
REQ-030 ALU instr, zero-wait imem_ack, wb_sel=1, alu_out=0x5 -> retire in cycle 4, wb_data=0x5, pc 0->4, instret 0->1.
REQ-031 Load, alu_out=0x100, dmem_ack delayed 3 cycles, dmem_rdata=0xDEADBEEF, wb_sel=2 -> dmem_addr=0x100 held 4 cycles, wb_data=0xDEADBEEF, single reg_wr_en pulse, 8 cycles total.
REQ-032 Branch: br_taken=1, alu_out=0x40 -> pc=0x40; then br_taken=1, alu_out=0x42 -> fault=1, state=5, pc stays 0x40, no further requests.
REQ-033 Timeout: TIMEOUT=16, imem_ack held 0 -> fault=1 after 16 FETCH cycles; imem_req=0 thereafter.
REQ-034 Counter wrap: CNT_W=4, 16 retired instructions -> instret returns to 0.
